// File: rtl/adc_frame_fifo_pkg.sv
// Shared register map and type definitions for the ADC frame FIFO.
// Holds the ADC_FIFO_STATUS / ADC_FIFO_DROP field positions, the frame FSM
// encoding and the default geometry used by the register block.
package adc_frame_fifo_pkg;

  // Default geometry (matches the v1 16-deep snapshot FIFO)
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_MAX_CH = 8;

  // ADC_FIFO_STATUS field positions
  localparam int STAT_LEVEL_LSB     = 0;
  localparam int STAT_LEVEL_MSB     = 15;
  localparam int STAT_OVERRUN_BIT   = 16;
  localparam int STAT_UNDERFLOW_BIT = 17;

  // ADC_FIFO_DROP field positions
  localparam int DROP_CNT_LSB = 0;
  localparam int DROP_CNT_MSB = 15;
  localparam int DROP_CNT_W   = DROP_CNT_MSB - DROP_CNT_LSB + 1;

  // Frame admission FSM. The reset/flush state is DISCARD so that stray
  // channel words seen before any status word are never stored.
  typedef enum logic {
    ST_DISCARD = 1'b0,
    ST_ADMIT   = 1'b1
  } frame_state_e;

  // A programmed frame length of 0 still occupies one word (the status word).
  function automatic int unsigned eff_frame_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/adc_frame_fifo_mem_sdp.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// The asynchronous read gives the show-ahead head word without a cycle of
// extra latency.
module fifo_mem_sdp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: one word per clock when enabled
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/adc_frame_fifo.sv
// ADC frame FIFO: buffers status + channel words from the non-stallable
// capture path for Wishbone readout. Supports word-drop and frame-atomic
// admission, sticky overrun/underflow flags, a saturating drop counter,
// a registered watermark interrupt and a synchronous flush.
module adc_frame_fifo
  import adc_frame_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int MAX_CH = DEF_MAX_CH,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         cfg_atomic,
  input  logic [$clog2(MAX_CH+2)-1:0]  cfg_frame_len,
  input  logic [LVL_W-1:0]             cfg_wm,
  input  logic                         pop,
  input  logic                         flush,
  input  logic                         clr_overrun,
  input  logic                         clr_underflow,
  output logic [DATA_W-1:0]            rd_data,
  output logic [LVL_W-1:0]             level,
  output logic                         overrun,
  output logic                         underflow,
  output logic [15:0]                  drop_cnt,
  output logic                         irq_wm
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  frame_state_e           state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   overrun_q, overrun_d;
  logic                   underflow_q, underflow_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic                   irq_wm_q, irq_wm_d;
  logic                   atomic_q, atomic_d;
  logic                   sof_seen_q, sof_seen_d;

  logic                   push_ok;
  logic                   pop_ok;
  logic                   pop_empty;
  logic                   drop_evt;
  logic                   room;
  logic                   fits;
  logic                   mode_atomic;
  logic [LVL_W-1:0]       space;
  logic [DATA_W-1:0]      mem_rdata;

  fifo_mem_sdp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i   (wb_clk_i),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign pop_ok    = pop && (level_q != '0);
  assign pop_empty = pop && (level_q == '0);
  assign room      = (level_q != FULL_LVL) || pop_ok;
  assign space     = FULL_LVL - level_q;
  // Admission ignores a same-cycle pop: only the current free space counts
  assign fits      = 32'(space) >= eff_frame_len(32'(cfg_frame_len));
  // Until the first SOF the live mode applies, so stray words in atomic
  // mode are discarded; afterwards the mode latched at the last SOF rules.
  assign mode_atomic = sof_seen_q ? atomic_q : cfg_atomic;

  // Admission FSM next state and push decision
  always_comb begin
    state_d    = state_q;
    atomic_d   = atomic_q;
    sof_seen_d = sof_seen_q;
    push_ok    = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        atomic_d   = cfg_atomic;
        sof_seen_d = 1'b1;
        if (cfg_atomic) begin
          if (fits) begin
            state_d = ST_ADMIT;
            push_ok = 1'b1;
          end else begin
            state_d = ST_DISCARD;
          end
        end else begin
          push_ok = room;
        end
      end else if (mode_atomic) begin
        // room guards against a producer that overruns its frame length
        push_ok = (state_q == ST_ADMIT) && room;
      end else begin
        push_ok = room;
      end
    end
    if (flush) begin
      state_d = ST_DISCARD;
      push_ok = 1'b0;
    end
  end

  assign drop_evt = in_valid && !push_ok;

  // Datapath next state: pointers, level, flags, counters
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overrun_d   = overrun_q;
    underflow_d = underflow_q;
    drop_cnt_d  = drop_cnt_q;
    irq_wm_d    = (cfg_wm != '0) && (level_q >= cfg_wm);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end

    // Set beats a same-cycle clear
    if (drop_evt)         overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;

    if (pop_empty)          underflow_d = 1'b1;
    else if (clr_underflow) underflow_d = 1'b0;

    if (drop_evt && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // Frame FSM and latched mode registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_DISCARD;
      atomic_q   <= 1'b0;
      sof_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      atomic_q   <= atomic_d;
      sof_seen_q <= sof_seen_d;
    end
  end

  // Pointer, level, flag, counter and interrupt registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overrun_q   <= 1'b0;
      underflow_q <= 1'b0;
      drop_cnt_q  <= '0;
      irq_wm_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overrun_q   <= overrun_d;
      underflow_q <= underflow_d;
      drop_cnt_q  <= drop_cnt_d;
      irq_wm_q    <= irq_wm_d;
    end
  end

  assign rd_data   = (level_q != '0) ? mem_rdata : '0;
  assign level     = level_q;
  assign overrun   = overrun_q;
  assign underflow = underflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign irq_wm    = irq_wm_q;

endmodule
